// File: rtl/stream_pkg.sv
// stream_pkg: FSM state enum, beat-counter width and NUM-wide data type for stream_arb
package stream_pkg;
`include "def.svh"
    typedef enum logic {IDLE, BUSY} state_t;
    localparam int CNT_W = 8;
    typedef logic signed [`NUM-1:0] num_t;
endpackage

// File: rtl/def.svh
// def.svh: shared data width NUM for the stream datapath
`ifndef DEF_SVH
`define DEF_SVH
`define NUM 16
`endif

// File: rtl/rr_pick.sv
// rr_pick: round-robin picker, first set req at or above ptr with wrap
//   req   : request vector
//   ptr   : search start index
//   grant : one-hot winner (all 0 when no request)
//   idx   : winner index
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IW = $clog2(N);
    logic found;
    always_comb begin
        grant = '0;
        idx = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            int c;
            c = (int'(ptr) + i) % N;
            if (!found && req[c]) begin
                found = 1'b1;
                idx = IW'(c);
                grant[c] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/stream_arb.sv
// stream_arb: round-robin burst arbiter of NREQ valid/stop streams onto one core stream
//   clk, rst_n     : clock, synchronous active-low reset
//   idata/ivalid   : requester data and valid, one lane per requester
//   istop          : backpressure to each requester
//   cdata/cvalid   : data and valid to the shared core
//   cstop          : backpressure from the core
//   ctag           : granted index, only when STREAM_ARB_TAG_EN is defined
module stream_arb
    import stream_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  num_t [NREQ-1:0]          idata,
    input  logic [NREQ-1:0]          ivalid,
    output logic [NREQ-1:0]          istop,
    output num_t                     cdata,
    output logic                     cvalid,
    input  logic                     cstop
`ifdef STREAM_ARB_TAG_EN
    ,
    output logic [$clog2(NREQ)-1:0]  ctag
`endif
);
    localparam int IW = $clog2(NREQ);
    state_t state, state_nx;
    logic [IW-1:0] g, g_nx, ptr, ptr_nx, pick_idx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [NREQ-1:0] pick_oh;
    logic busy, xfer;

    rr_pick #(.N(NREQ)) u_pick (
        .req   (ivalid),
        .ptr   (ptr),
        .grant (pick_oh),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            g <= '0;
            ptr <= '0;
            cnt <= '0;
        end else begin
            state <= state_nx;
            g <= g_nx;
            ptr <= ptr_nx;
            cnt <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        g_nx = g;
        ptr_nx = ptr;
        cnt_nx = cnt;
        busy = state == BUSY;
        xfer = busy && ivalid[g] && !cstop;
        cdata = busy ? idata[g] : '0;
        cvalid = busy && ivalid[g];
        istop = '1;
        if (busy)
            istop[g] = cstop;
        if (!busy) begin
            if (|pick_oh) begin
                state_nx = BUSY;
                g_nx = pick_idx;
                cnt_nx = '0;
            end
        end else begin
            cnt_nx = cnt + CNT_W'(xfer);
            // a gap (granted valid low) releases without transferring, even under cstop
            if (!ivalid[g] || (xfer && cnt == CNT_W'(BURST - 1))) begin
                state_nx = IDLE;
                ptr_nx = (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;
            end
        end
    end

`ifdef STREAM_ARB_TAG_EN
    assign ctag = busy ? g : '0;
`endif
endmodule
